flip_engine: RTL and testbench
==============================

Name: flip_engine

Overview:
- Resolves one Othello move against the 8x8 board store.
- Downstream of the cursor/control datapath: it takes the confirmed cursor position and side to move.
- Upstream of the board RAM write port and the cell-redraw path.
- Walks all 8 directions from the target cell, flips every bracketed opponent disk, then writes the placed disk; reports legality and flip count to control.

Parameters:
- READ_LAT, 1, board read latency in cycles (address in cycle N, data valid in cycle N+READ_LAT); legal values 1 or 2.
- EMPTY_CODE, 2'b00, board encoding of an empty cell; 2'b01 = black, 2'b10 = white, 2'b11 is treated as empty.

Ports:
- clock  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- side  in  2  mover colour (2'b01 or 2'b10), latched on start
- x  in  3  target column, latched on start
- y  in  3  target row (0 = top), latched on start
- rd_x  out  3  board read column
- rd_y  out  3  board read row
- rd_q  in  2  board read data
- wr_en  out  1  board write strobe, one cell per cycle
- wr_x  out  3  write column
- wr_y  out  3  write row
- wr_data  out  2  write value (always the latched side)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of move
- valid  out  1  held from done until next accepted start: 1 = move legal (>=1 flip)
- flip_count  out  6  total disks flipped, held like valid

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- Reset mid-operation: the FSM aborts immediately, already-issued writes stand, and no done is generated.
- FSM states: IDLE, CHECK, DIR_INIT, STEP, WAIT, EVAL, FLIP, PLACE, FINISH.
- IDLE: on start, latch side, x, y; clear dir, run and total; go to CHECK. start is ignored in every other state.
- CHECK: read the target cell.
  - If the side is invalid (00 or 11), or the target is non-empty: go to FINISH with valid=0 and flip_count=0. No writes occur.
  - Otherwise go to DIR_INIT.
- Directions, in fixed order 0..7 as (dx,dy): (0,-1), (1,-1), (1,0), (1,1), (0,1), (-1,1), (-1,0), (-1,-1).
- DIR_INIT: set the cursor to (x,y) and run=0.
- STEP: cursor += delta, using signed 4-bit arithmetic.
  - If the result is outside 0..7, the direction fails: dir++.
  - Otherwise drive rd_x/rd_y and wait READ_LAT cycles (WAIT), then EVAL.
- EVAL:
  - opponent: run++, back to STEP.
  - empty or 11: direction fails.
  - own colour with run=0: direction fails.
  - own colour with run>0: go to FLIP.
- FLIP:
  - Restart from (x,y) + delta.
  - Write side to run consecutive cells, one per cycle, with wr_en high for exactly run cycles.
  - Then total += run and dir++.
- After dir 7: if total>0, go to PLACE; else go to FINISH with valid=0.
- PLACE: one wr_en cycle writing side at (x,y).
- FINISH: pulse done, assert valid = (total>0), flip_count = total, then return to IDLE. busy drops in the same cycle done rises.
- Flips in one direction never alter cells read in a later direction. Because flipped cells become the mover's colour, the later-direction result equals the result on the original board.
- Maximum total is 18 (fits 6 bits). Worst-case latency is bounded: about 8*(8*(READ_LAT+2)) + 20 cycles.

Optional Feature:
- FLIP_DRAW_EN defined:
  - Adds outputs draw_req (1), draw_x (3), draw_y (3), draw_sel (2) and input draw_ack (1).
  - Every board write is also presented as a draw request. The FSM holds in FLIP/PLACE until draw_ack; request fields are stable while draw_req is high.
- Not defined:
  - Those ports are absent and writes proceed one per cycle.
  - The control block then redraws the full board after done.

Test Plan:
- Standard opening (board (3,3)=10, (4,3)=01, (3,4)=01, (4,4)=10); black start at x=3,y=2 -> single wr (3,3)=01, then wr (3,2)=01; done with valid=1, flip_count=1.
- Same board, black at (0,0) -> no wr_en; done with valid=0, flip_count=0.
- Target (3,3) occupied, any side -> done within 5 cycles, no writes, valid=0.
- Row y=0: black at (0,0), white at (1,0)..(7,0) (bracket runs to the edge, no own disk) -> no flip in that direction, valid=0.
- Multi-direction: black at (2,2), white at (3,3),(2,3),(3,2), black at (4,4),(2,4),(4,2) -> 3 flips plus place; flip_count=3, writes in direction order 2,3,4.
- Assert resetn low during FLIP -> all outputs 0 asynchronously, no done; a subsequent start is accepted normally.

Source files
------------

// File: rtl/flip_engine.sv
// flip_engine: resolves one Othello move against the 8x8 board store.
// Walks the 8 directions from the target cell, flips bracketed opponent disks,
// then writes the placed disk and reports legality and flip count.
// Optional macro FLIP_DRAW_EN: mirrors every board write as a draw request and
// holds each write until draw_ack.
module flip_engine #(
    parameter int unsigned READ_LAT   = 1,
    parameter logic [1:0]  EMPTY_CODE = 2'b00
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] side,
    input  logic [2:0] x,
    input  logic [2:0] y,
    output logic [2:0] rd_x,
    output logic [2:0] rd_y,
    input  logic [1:0] rd_q,
    output logic       wr_en,
    output logic [2:0] wr_x,
    output logic [2:0] wr_y,
    output logic [1:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       valid,
    output logic [5:0] flip_count
`ifdef FLIP_DRAW_EN
    ,
    output logic       draw_req,
    output logic [2:0] draw_x,
    output logic [2:0] draw_y,
    output logic [1:0] draw_sel,
    input  logic       draw_ack
`endif
);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_CHECK    = 4'd1;
    localparam logic [3:0] ST_DIR_INIT = 4'd2;
    localparam logic [3:0] ST_STEP     = 4'd3;
    localparam logic [3:0] ST_WAIT     = 4'd4;
    localparam logic [3:0] ST_EVAL     = 4'd5;
    localparam logic [3:0] ST_FLIP     = 4'd6;
    localparam logic [3:0] ST_PLACE    = 4'd7;
    localparam logic [3:0] ST_FINISH   = 4'd8;

    logic [3:0] state_q, state_d;
    logic [1:0] side_q, side_d;
    logic [2:0] x_q, x_d, y_q, y_d;
    logic [2:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [2:0] dir_q, dir_d;
    logic [2:0] run_q, run_d;
    logic [2:0] fcnt_q, fcnt_d;
    logic [5:0] total_q, total_d;
    logic [1:0] cnt_q, cnt_d;
    logic       valid_q, valid_d;
    logic [5:0] fc_q, fc_d;

    logic [3:0] dx, dy;
    logic [3:0] nx, ny;
    logic       adv_dir;
    logic       wr_go;
    logic       cell_empty;
    logic [1:0] opp;

`ifdef FLIP_DRAW_EN
    assign wr_go = draw_ack;
`else
    assign wr_go = 1'b1;
`endif

    // Direction decode: deltas as 4-bit two's complement.
    always_comb begin
        dx = 4'd0;
        dy = 4'd0;
        unique case (dir_q)
            3'd0: begin dx = 4'h0; dy = 4'hF; end
            3'd1: begin dx = 4'h1; dy = 4'hF; end
            3'd2: begin dx = 4'h1; dy = 4'h0; end
            3'd3: begin dx = 4'h1; dy = 4'h1; end
            3'd4: begin dx = 4'h0; dy = 4'h1; end
            3'd5: begin dx = 4'hF; dy = 4'h1; end
            3'd6: begin dx = 4'hF; dy = 4'h0; end
            default: begin dx = 4'hF; dy = 4'hF; end
        endcase
    end

    // Stepped cursor; bit 3 set means the step left the board on either side.
    assign nx = {1'b0, cur_x_q} + dx;
    assign ny = {1'b0, cur_y_q} + dy;

    assign cell_empty = (rd_q == EMPTY_CODE) || (rd_q == 2'b11);
    assign opp        = side_q ^ 2'b11;

    // Next-state logic for the move walker.
    always_comb begin
        state_d = state_q;
        side_d  = side_q;
        x_d     = x_q;
        y_d     = y_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        dir_d   = dir_q;
        run_d   = run_q;
        fcnt_d  = fcnt_q;
        total_d = total_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        fc_d    = fc_q;
        adv_dir = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    side_d  = side;
                    x_d     = x;
                    y_d     = y;
                    cur_x_d = x;
                    cur_y_d = y;
                    dir_d   = 3'd0;
                    run_d   = 3'd0;
                    total_d = 6'd0;
                    cnt_d   = 2'd0;
                    valid_d = 1'b0;
                    fc_d    = 6'd0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (cnt_q == 2'(READ_LAT)) begin
                    if (side_q == 2'b00 || side_q == 2'b11 || !cell_empty) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_DIR_INIT;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_DIR_INIT: begin
                cur_x_d = x_q;
                cur_y_d = y_q;
                run_d   = 3'd0;
                state_d = ST_STEP;
            end
            ST_STEP: begin
                if (nx[3] || ny[3]) begin
                    adv_dir = 1'b1;
                end else begin
                    cur_x_d = nx[2:0];
                    cur_y_d = ny[2:0];
                    cnt_d   = 2'd0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 2'(READ_LAT - 1)) begin
                    state_d = ST_EVAL;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_EVAL: begin
                if (rd_q == opp) begin
                    run_d   = run_q + 3'd1;
                    state_d = ST_STEP;
                end else if (!cell_empty && rd_q == side_q && run_q != 3'd0) begin
                    // Restart just past the target; the bracket is known in range.
                    cur_x_d = x_q + dx[2:0];
                    cur_y_d = y_q + dy[2:0];
                    fcnt_d  = 3'd0;
                    state_d = ST_FLIP;
                end else begin
                    adv_dir = 1'b1;
                end
            end
            ST_FLIP: begin
                if (wr_go) begin
                    cur_x_d = nx[2:0];
                    cur_y_d = ny[2:0];
                    fcnt_d  = fcnt_q + 3'd1;
                    if (fcnt_q + 3'd1 == run_q) begin
                        total_d = total_q + {3'd0, run_q};
                        adv_dir = 1'b1;
                    end
                end
            end
            ST_PLACE: begin
                if (wr_go) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (adv_dir) begin
            if (dir_q == 3'd7) begin
                if (total_d != 6'd0) begin
                    cur_x_d = x_q;
                    cur_y_d = y_q;
                    state_d = ST_PLACE;
                end else begin
                    state_d = ST_FINISH;
                end
            end else begin
                dir_d   = dir_q + 3'd1;
                state_d = ST_DIR_INIT;
            end
        end

        // Results are registered on entry so they are visible alongside done.
        if (state_d == ST_FINISH && state_q != ST_FINISH) begin
            valid_d = (total_d != 6'd0);
            fc_d    = total_d;
        end
    end

    // State registers with asynchronous abort.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            side_q  <= 2'b00;
            x_q     <= 3'd0;
            y_q     <= 3'd0;
            cur_x_q <= 3'd0;
            cur_y_q <= 3'd0;
            dir_q   <= 3'd0;
            run_q   <= 3'd0;
            fcnt_q  <= 3'd0;
            total_q <= 6'd0;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
            fc_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            side_q  <= side_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            dir_q   <= dir_d;
            run_q   <= run_d;
            fcnt_q  <= fcnt_d;
            total_q <= total_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            fc_q    <= fc_d;
        end
    end

    // Output decode; the cursor doubles as read and write address.
    always_comb begin
        rd_x       = cur_x_q;
        rd_y       = cur_y_q;
        wr_x       = cur_x_q;
        wr_y       = cur_y_q;
        wr_data    = side_q;
        wr_en      = (state_q == ST_FLIP || state_q == ST_PLACE) && wr_go;
        busy       = (state_q != ST_IDLE) && (state_q != ST_FINISH);
        done       = (state_q == ST_FINISH);
        valid      = valid_q;
        flip_count = fc_q;
`ifdef FLIP_DRAW_EN
        draw_req   = (state_q == ST_FLIP || state_q == ST_PLACE);
        draw_x     = cur_x_q;
        draw_y     = cur_y_q;
        draw_sel   = side_q;
`endif
    end

endmodule

// File: tb/tb_flip_engine.sv
// Directed bench for flip_engine: board store model with 1-cycle read latency,
// write log, and hand-computed expectations for each move.
module tb_flip_engine;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [1:0] side = 2'b00;
    logic [2:0] x = 3'd0;
    logic [2:0] y = 3'd0;
    logic [2:0] rd_x, rd_y;
    logic [1:0] rd_q = 2'b00;
    logic       wr_en;
    logic [2:0] wr_x, wr_y;
    logic [1:0] wr_data;
    logic       busy, done, valid;
    logic [5:0] flip_count;

    int total = 0;
    int bad = 0;

    logic [1:0] brd [8][8];
    logic [2:0] wlx [64];
    logic [2:0] wly [64];
    logic [1:0] wld [64];
    int wn = 0;
    int dn = 0;

    flip_engine #(.READ_LAT(1), .EMPTY_CODE(2'b00)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .side       (side),
        .x          (x),
        .y          (y),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_q       (rd_q),
        .wr_en      (wr_en),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .valid      (valid),
        .flip_count (flip_count)
    );

    always #5 clock = ~clock;

    // Board store: synchronous read, writes logged in issue order.
    always @(posedge clock) begin
        rd_q <= brd[rd_y][rd_x];
        if (wr_en) begin
            wlx[wn[5:0]] <= wr_x;
            wly[wn[5:0]] <= wr_y;
            wld[wn[5:0]] <= wr_data;
            wn <= wn + 1;
        end
        if (done) dn <= dn + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] went(input int i);
        return {wlx[i[5:0]], wly[i[5:0]], wld[i[5:0]]};
    endfunction

    task automatic clear_board();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                brd[r][c] = 2'b00;
    endtask

    task automatic std_board();
        clear_board();
        brd[3][3] = 2'b10;
        brd[3][4] = 2'b01;
        brd[4][3] = 2'b01;
        brd[4][4] = 2'b10;
    endtask

    // Issue one move and wait (bounded) for done; returns results and write base.
    task automatic run_move(input logic [1:0] s, input logic [2:0] mx, input logic [2:0] my,
                            output logic v, output logic [5:0] fc, output int base,
                            output int cyc);
        @(posedge clock); #1;
        side = s; x = mx; y = my; start = 1'b1;
        base = wn;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 1000) begin
            @(posedge clock); #1;
            cyc++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        v = valid;
        fc = flip_count;
    endtask

    logic       v;
    logic [5:0] fc;
    int         base, cyc, dn0;

    initial begin
        std_board();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_fc", {26'd0, flip_count}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        resetn = 1'b1;

        // Standard opening, black at (3,2): flips (3,3) then places.
        run_move(2'b01, 3'd3, 3'd2, v, fc, base, cyc);
        chk("open_valid", {31'd0, v}, 32'd1);
        chk("open_fc", {26'd0, fc}, 32'd1);
        chk("open_nwr", wn - base, 32'd2);
        chk("open_w0", {24'd0, went(base)}, {24'd0, 3'd3, 3'd3, 2'b01});
        chk("open_w1", {24'd0, went(base + 1)}, {24'd0, 3'd3, 3'd2, 2'b01});
        repeat (3) @(posedge clock);
        #1;
        chk("open_valid_held", {31'd0, valid}, 32'd1);
        chk("open_fc_held", {26'd0, flip_count}, 32'd1);

        // Black at (0,0): nothing bracketed.
        std_board();
        run_move(2'b01, 3'd0, 3'd0, v, fc, base, cyc);
        chk("corner_valid", {31'd0, v}, 32'd0);
        chk("corner_fc", {26'd0, fc}, 32'd0);
        chk("corner_nwr", wn - base, 32'd0);

        // Occupied target: quick reject, no writes.
        run_move(2'b10, 3'd3, 3'd3, v, fc, base, cyc);
        chk("occ_valid", {31'd0, v}, 32'd0);
        chk("occ_nwr", wn - base, 32'd0);
        chk("occ_fast", {31'd0, (cyc <= 5)}, 32'd1);

        // Invalid side on an empty cell next to a bracket: rejected.
        run_move(2'b11, 3'd3, 3'd2, v, fc, base, cyc);
        chk("badside_valid", {31'd0, v}, 32'd0);
        chk("badside_nwr", wn - base, 32'd0);

        // Opponent run reaches the edge with no closing disk.
        clear_board();
        for (int c = 1; c < 8; c++) brd[0][c] = 2'b10;
        run_move(2'b01, 3'd0, 3'd0, v, fc, base, cyc);
        chk("edge_valid", {31'd0, v}, 32'd0);
        chk("edge_fc", {26'd0, fc}, 32'd0);
        chk("edge_nwr", wn - base, 32'd0);

        // Three directions flip, in order 2,3,4, then place.
        clear_board();
        brd[3][3] = 2'b10; brd[3][2] = 2'b10; brd[2][3] = 2'b10;
        brd[4][4] = 2'b01; brd[4][2] = 2'b01; brd[2][4] = 2'b01;
        run_move(2'b01, 3'd2, 3'd2, v, fc, base, cyc);
        chk("multi_valid", {31'd0, v}, 32'd1);
        chk("multi_fc", {26'd0, fc}, 32'd3);
        chk("multi_nwr", wn - base, 32'd4);
        chk("multi_w0", {24'd0, went(base)}, {24'd0, 3'd3, 3'd2, 2'b01});
        chk("multi_w1", {24'd0, went(base + 1)}, {24'd0, 3'd3, 3'd3, 2'b01});
        chk("multi_w2", {24'd0, went(base + 2)}, {24'd0, 3'd2, 3'd3, 2'b01});
        chk("multi_w3", {24'd0, went(base + 3)}, {24'd0, 3'd2, 3'd2, 2'b01});

        // Reset asserted while flipping: immediate clear, no done afterwards.
        @(posedge clock); #1;
        side = 2'b01; x = 3'd2; y = 3'd2; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 0;
        while (!wr_en && cyc < 1000) begin
            @(posedge clock); #1;
            cyc++;
        end
        chk("flip_seen", {31'd0, wr_en}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        dn0 = dn;
        chk("arst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_valid", {31'd0, valid}, 32'd0);
        chk("arst_fc", {26'd0, flip_count}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        chk("arst_no_done", dn - dn0, 32'd0);

        // Normal start after abort.
        std_board();
        run_move(2'b01, 3'd3, 3'd2, v, fc, base, cyc);
        chk("after_valid", {31'd0, v}, 32'd1);
        chk("after_fc", {26'd0, fc}, 32'd1);
        chk("after_nwr", wn - base, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
